pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives hold/flush of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Its idex_flush feeds the ID/EX register's synchronous bubble input.
- Detects load-use and early-operand (jr) hazards, squashes on taken branch/jump, and freezes the pipe during multi-cycle data-memory accesses, with timeout.

Parameters:
- MEM_TIMEOUT, 64: max MEM_WAIT cycles before abort.
- CNT_W, 16: width of performance counters (feature only).

Ports:
- clk  in  1  clock.
- reset  in  1  async active-high reset.
- id_rs  in  5  rs field of the ID instruction.
- id_rt  in  5  rt field of the ID instruction.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_jump  in  1  j/jal/jr/jalr decoded in ID (target resolved in ID).
- id_jr  in  1  jr/jalr (needs rs in ID).
- ex_memrd  in  1  EX instruction is a load.
- ex_regwr  in  1  EX instruction writes a register.
- ex_wdst  in  5  EX destination register (post-RegDst).
- mem_memrd  in  1  MEM instruction is a load.
- mem_wdst  in  5  MEM destination register.
- ex_br_taken  in  1  branch resolved taken in EX.
- mem_req  in  1  MEM stage is accessing data memory.
- mem_ack  in  1  data memory completes this cycle.
- pc_hold  out  1  PC keeps its value.
- ifid_hold  out  1  IF/ID keeps its value.
- ifid_flush  out  1  IF/ID loads a bubble.
- idex_hold  out  1  ID/EX keeps its value.
- idex_flush  out  1  ID/EX loads a bubble.
- exmem_hold  out  1  EX/MEM keeps its value.
- memwb_flush  out  1  MEM/WB loads a bubble.
- mem_timeout  out  1  sticky error flag.

Behaviour:
- Reset: reset clk; asynchronous, active-high.
  - While reset is asserted: state=RUN, wait counter=0, mem_timeout=0, all hold/flush outputs=0.
  - Reset asserted mid-MEM_WAIT aborts the wait immediately.
- States: RUN, MEM_WAIT. All hold/flush outputs are combinational (Mealy) from state and inputs, with zero latency: they act at the same clock edge.
- Hazard terms (register 0 never hazards):
  - LU = ex_memrd & ((id_use_rs & id_rs==ex_wdst) | (id_use_rt & id_rt==ex_wdst)).
  - JRH = id_jr & ((ex_regwr & id_rs==ex_wdst) | (mem_memrd & id_rs==mem_wdst)).
- Stall/flush rules, in priority order:
  1. MEM_STALL = (RUN & mem_req & !mem_ack) | (MEM_WAIT & !mem_ack & !timeout_hit) -> pc_hold, ifid_hold, idex_hold, exmem_hold, memwb_flush = 1. All other outputs 0.
  2. ex_br_taken -> ifid_flush=1, idex_flush=1. No holds.
  3. LU | JRH -> pc_hold=1, ifid_hold=1, idex_flush=1.
  4. id_jump -> ifid_flush=1.
  5. Otherwise all outputs 0.
- A suppressed lower-priority event is re-evaluated the next cycle; it is not latched.
- FSM transitions:
  - RUN -> MEM_WAIT when mem_req & !mem_ack. The counter loads 1.
  - MEM_WAIT + mem_ack -> RUN. The pipe advances in that same cycle (no holds asserted).
  - MEM_WAIT + !mem_ack: counter increments.
  - timeout_hit = counter==MEM_TIMEOUT. When it is set in MEM_WAIT:
    - holds released that cycle;
    - memwb_flush=1 (the access is discarded);
    - mem_timeout set, and it stays set until reset;
    - next state RUN.
  - RUN with mem_req & mem_ack in the same cycle: no stall, state unchanged.
- Counter width is $clog2(MEM_TIMEOUT+1). The counter never wraps.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- Defined: adds outputs perf_lu [CNT_W], perf_flush [CNT_W], perf_memwait [CNT_W].
  - Increment conditions, each counter incremented once per qualifying cycle:
    - perf_lu: rule 3 fires.
    - perf_flush: rule 2 or rule 4 fires.
    - perf_memwait: MEM_STALL=1.
  - Counters saturate at all-ones and reset to 0.
- Undefined: these ports and registers are absent. Core behaviour is identical either way.

Decomposition:
- Shared package pipe_pkg holds:
  - state enum (RUN=0, MEM_WAIT=1);
  - REG_ZERO=5'd0 constant;
  - reg-address width constant 5.
- One natural sub-module: hazard_cmp, the combinational LU/JRH comparator, reusable by the forwarding unit.

Test Plan:
- Load-use: ex_memrd=1, ex_wdst=8, id_rs=8, id_use_rs=1 -> pc_hold=ifid_hold=idex_flush=1 for exactly 1 cycle. With ex_wdst=0 -> no stall.
- Branch beats load-use: ex_br_taken=1 while the LU condition is true -> ifid_flush=idex_flush=1, pc_hold=0.
- jr after load: id_jr=1, id_rs=31.
  - Cycle 1: ex_memrd=1, ex_wdst=31 -> stall.
  - Cycle 2: mem_memrd=1, mem_wdst=31 -> stall.
  - Cycle 3: id_jump -> ifid_flush=1.
- Memory wait: mem_req=1, mem_ack=0 for 3 cycles, then ack -> 3 cycles of all holds plus memwb_flush, release in the ack cycle, state RUN. Same-cycle req+ack -> no stall.
- Timeout: MEM_TIMEOUT=4, ack never asserted -> 4 hold cycles (entry cycle plus counter 1..3), then release with memwb_flush=1; mem_timeout=1 persists until reset.
- Reset mid-MEM_WAIT -> outputs 0 asynchronously, state RUN; with PIPE_HAZARD_PERF_EN, counters read 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: FSM states and register-address constants.
package pipe_pkg;

   localparam int unsigned REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Combinational load-use / jr-operand hazard comparator; register 0 never hazards.
module hazard_cmp
   import pipe_pkg::*;
(
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_jr,
   input  logic             ex_memrd,
   input  logic             ex_regwr,
   input  logic [REG_W-1:0] ex_wdst,
   input  logic             mem_memrd,
   input  logic [REG_W-1:0] mem_wdst,
   output logic             lu,
   output logic             jrh
);

   logic rs_ex, rt_ex, rs_mem;

   always_comb begin
      rs_ex  = (ex_wdst != REG_ZERO) && (id_rs == ex_wdst);
      rt_ex  = (ex_wdst != REG_ZERO) && (id_rt == ex_wdst);
      rs_mem = (mem_wdst != REG_ZERO) && (id_rs == mem_wdst);
      lu     = ex_memrd && ((id_use_rs && rs_ex) || (id_use_rt && rt_ex));
      jrh    = id_jr && ((ex_regwr && rs_ex) || (mem_memrd && rs_mem));
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with memory-wait timeout.
// Optional performance counters enabled by PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_jump,
   input  logic             id_jr,
   input  logic             ex_memrd,
   input  logic             ex_regwr,
   input  logic [REG_W-1:0] ex_wdst,
   input  logic             mem_memrd,
   input  logic [REG_W-1:0] mem_wdst,
   input  logic             ex_br_taken,
   input  logic             mem_req,
   input  logic             mem_ack,
   output logic             pc_hold,
   output logic             ifid_hold,
   output logic             ifid_flush,
   output logic             idex_hold,
   output logic             idex_flush,
   output logic             exmem_hold,
   output logic             memwb_flush,
   output logic             mem_timeout
`ifdef PIPE_HAZARD_PERF_EN
   ,
   output logic [CNT_W-1:0] perf_lu,
   output logic [CNT_W-1:0] perf_flush,
   output logic [CNT_W-1:0] perf_memwait
`endif
);

   localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

   state_t        state, state_nxt;
   logic [CW-1:0] wait_cnt, wait_cnt_nxt;
   logic          lu, jrh;
   logic          timeout_hit, mem_stall, to_set;
   logic          rule_br, rule_lu, rule_jmp;

   hazard_cmp u_hazard_cmp (
      .id_rs     (id_rs),
      .id_rt     (id_rt),
      .id_use_rs (id_use_rs),
      .id_use_rt (id_use_rt),
      .id_jr     (id_jr),
      .ex_memrd  (ex_memrd),
      .ex_regwr  (ex_regwr),
      .ex_wdst   (ex_wdst),
      .mem_memrd (mem_memrd),
      .mem_wdst  (mem_wdst),
      .lu        (lu),
      .jrh       (jrh)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= RUN;
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else begin
         state       <= state_nxt;
         wait_cnt    <= wait_cnt_nxt;
         mem_timeout <= mem_timeout | to_set;
      end
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      to_set       = 1'b0;
      timeout_hit  = (state == MEM_WAIT) && (wait_cnt == CW'(MEM_TIMEOUT));
      mem_stall    = 1'b0;
      case (state)
         RUN: begin
            if (mem_req && !mem_ack) begin
               state_nxt    = MEM_WAIT;
               wait_cnt_nxt = CW'(1);
               mem_stall    = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (mem_ack) begin
               state_nxt    = RUN;
               wait_cnt_nxt = '0;
            end else if (timeout_hit) begin
               state_nxt    = RUN;
               wait_cnt_nxt = '0;
               to_set       = 1'b1;
            end else begin
               wait_cnt_nxt = wait_cnt + CW'(1);
               mem_stall    = 1'b1;
            end
         end
         default: begin
            state_nxt    = RUN;
            wait_cnt_nxt = '0;
         end
      endcase

      rule_br  = !mem_stall && ex_br_taken;
      rule_lu  = !mem_stall && !ex_br_taken && (lu || jrh);
      rule_jmp = !mem_stall && !ex_br_taken && !(lu || jrh) && id_jump;
   end

   // Mealy outputs are forced low while reset is asserted, even with hazards present.
   always_comb begin
      pc_hold     = 1'b0;
      ifid_hold   = 1'b0;
      ifid_flush  = 1'b0;
      idex_hold   = 1'b0;
      idex_flush  = 1'b0;
      exmem_hold  = 1'b0;
      memwb_flush = 1'b0;
      if (!reset) begin
         if (mem_stall) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_hold   = 1'b1;
            exmem_hold  = 1'b1;
            memwb_flush = 1'b1;
         end else begin
            memwb_flush = timeout_hit;
            if (rule_br) begin
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end else if (rule_lu) begin
               pc_hold    = 1'b1;
               ifid_hold  = 1'b1;
               idex_flush = 1'b1;
            end else if (rule_jmp) begin
               ifid_flush = 1'b1;
            end
         end
      end
   end

`ifdef PIPE_HAZARD_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_lu      <= '0;
         perf_flush   <= '0;
         perf_memwait <= '0;
      end else begin
         if (rule_lu && (perf_lu != '1))
            perf_lu <= perf_lu + CNT_W'(1);
         if ((rule_br || rule_jmp) && (perf_flush != '1))
            perf_flush <= perf_flush + CNT_W'(1);
         if (mem_stall && (perf_memwait != '1))
            perf_memwait <= perf_memwait + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized run against a reference model.
module tb_pipe_hazard_ctrl;

   localparam int TMO = 4;

   // Output vector order: pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold, memwb_flush
   localparam logic [6:0] V_NONE  = 7'b0000000;
   localparam logic [6:0] V_STALL = 7'b1101011;
   localparam logic [6:0] V_BR    = 7'b0010100;
   localparam logic [6:0] V_LU    = 7'b1100100;
   localparam logic [6:0] V_JMP   = 7'b0010000;
   localparam logic [6:0] V_TOHIT = 7'b0000001;

   logic       clk, reset;
   logic [4:0] id_rs, id_rt, ex_wdst, mem_wdst;
   logic       id_use_rs, id_use_rt, id_jump, id_jr;
   logic       ex_memrd, ex_regwr, mem_memrd, ex_br_taken, mem_req, mem_ack;
   logic       pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold, memwb_flush;
   logic       mem_timeout;
`ifdef PIPE_HAZARD_PERF_EN
   logic [15:0] perf_lu, perf_flush, perf_memwait;
`endif
   logic [6:0] dut_v;

   int total = 0;
   int bad   = 0;

   // Reference model state
   bit m_wait;
   int m_cnt;
   bit m_to;
   int m_plu, m_pfl, m_pmw;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_use_rs   (id_use_rs),
      .id_use_rt   (id_use_rt),
      .id_jump     (id_jump),
      .id_jr       (id_jr),
      .ex_memrd    (ex_memrd),
      .ex_regwr    (ex_regwr),
      .ex_wdst     (ex_wdst),
      .mem_memrd   (mem_memrd),
      .mem_wdst    (mem_wdst),
      .ex_br_taken (ex_br_taken),
      .mem_req     (mem_req),
      .mem_ack     (mem_ack),
      .pc_hold     (pc_hold),
      .ifid_hold   (ifid_hold),
      .ifid_flush  (ifid_flush),
      .idex_hold   (idex_hold),
      .idex_flush  (idex_flush),
      .exmem_hold  (exmem_hold),
      .memwb_flush (memwb_flush),
      .mem_timeout (mem_timeout)
`ifdef PIPE_HAZARD_PERF_EN
      ,
      .perf_lu      (perf_lu),
      .perf_flush   (perf_flush),
      .perf_memwait (perf_memwait)
`endif
   );

   assign dut_v = {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold, memwb_flush};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic bit m_lu();
      return ex_memrd && ex_wdst != 0 &&
             ((id_use_rs && id_rs == ex_wdst) || (id_use_rt && id_rt == ex_wdst));
   endfunction

   function automatic bit m_jrh();
      return id_jr && ((ex_regwr && ex_wdst != 0 && id_rs == ex_wdst) ||
                       (mem_memrd && mem_wdst != 0 && id_rs == mem_wdst));
   endfunction

   function automatic bit m_hit();
      return m_wait && m_cnt == TMO;
   endfunction

   function automatic bit m_stall();
      return m_wait ? (!mem_ack && !m_hit()) : (mem_req && !mem_ack);
   endfunction

   function automatic logic [6:0] model_out();
      if (m_stall())          return V_STALL;
      if (ex_br_taken)        return V_BR | (m_hit() ? V_TOHIT : V_NONE);
      if (m_lu() || m_jrh())  return V_LU | (m_hit() ? V_TOHIT : V_NONE);
      if (id_jump)            return V_JMP | (m_hit() ? V_TOHIT : V_NONE);
      return m_hit() ? V_TOHIT : V_NONE;
   endfunction

   task automatic model_reset();
      m_wait = 0; m_cnt = 0; m_to = 0;
      m_plu = 0; m_pfl = 0; m_pmw = 0;
   endtask

   task automatic model_step();
      bit st, hz;
      st = m_stall();
      hz = m_lu() || m_jrh();
      if (st) m_pmw++;
      else if (ex_br_taken) m_pfl++;
      else if (hz) m_plu++;
      else if (id_jump) m_pfl++;
      if (m_wait) begin
         if (mem_ack) m_wait = 0;
         else if (m_hit()) begin m_wait = 0; m_to = 1; end
         else m_cnt++;
      end else if (mem_req && !mem_ack) begin
         m_wait = 1;
         m_cnt  = 1;
      end
   endtask

   // Advance one clock: model follows the active edge, then return to the falling edge to drive.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      id_rs = 0; id_rt = 0; ex_wdst = 0; mem_wdst = 0;
      id_use_rs = 0; id_use_rt = 0; id_jump = 0; id_jr = 0;
      ex_memrd = 0; ex_regwr = 0; mem_memrd = 0;
      ex_br_taken = 0; mem_req = 0; mem_ack = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b1;
      ex_memrd = 1; ex_wdst = 8; id_rs = 8; id_use_rs = 1; mem_req = 1;
      model_reset();
      #12;
      total++;
      if (dut_v !== V_NONE) begin bad++; $display("FAIL reset_outputs act=%b req=%b", dut_v, V_NONE); end
      total++;
      if (mem_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout act=%b req=0", mem_timeout); end
      @(negedge clk);
      clear_inputs();
      reset = 1'b0;
      #1;
      total++;
      if (dut_v !== V_NONE) begin bad++; $display("FAIL reset_release act=%b req=%b", dut_v, V_NONE); end
      @(negedge clk);
   endtask

   task automatic test_load_use();
      clear_inputs();
      ex_memrd = 1; ex_wdst = 8; id_rs = 8; id_use_rs = 1;
      #1;
      total++;
      if (dut_v !== V_LU) begin bad++; $display("FAIL lu_rs act=%b req=%b", dut_v, V_LU); end
      tick();
      ex_memrd = 0; ex_wdst = 0;
      #1;
      total++;
      if (dut_v !== V_NONE) begin bad++; $display("FAIL lu_one_cycle act=%b req=%b", dut_v, V_NONE); end
      tick();
      ex_memrd = 1; ex_wdst = 0; id_rs = 0;
      #1;
      total++;
      if (dut_v !== V_NONE) begin bad++; $display("FAIL lu_reg_zero act=%b req=%b", dut_v, V_NONE); end
      tick();
      id_use_rs = 0; id_rs = 3; id_use_rt = 1; id_rt = 9; ex_wdst = 9;
      #1;
      total++;
      if (dut_v !== V_LU) begin bad++; $display("FAIL lu_rt act=%b req=%b", dut_v, V_LU); end
      tick();
      id_use_rt = 0;
      #1;
      total++;
      if (dut_v !== V_NONE) begin bad++; $display("FAIL lu_rt_unused act=%b req=%b", dut_v, V_NONE); end
      tick();
   endtask

   task automatic test_branch_priority();
      clear_inputs();
      ex_memrd = 1; ex_wdst = 8; id_rs = 8; id_use_rs = 1; ex_br_taken = 1;
      #1;
      total++;
      if (dut_v !== V_BR) begin bad++; $display("FAIL br_over_lu act=%b req=%b", dut_v, V_BR); end
      tick();
      clear_inputs();
      ex_br_taken = 1; id_jump = 1;
      #1;
      total++;
      if (dut_v !== V_BR) begin bad++; $display("FAIL br_over_jump act=%b req=%b", dut_v, V_BR); end
      tick();
   endtask

   task automatic test_jr();
      clear_inputs();
      id_jr = 1; id_jump = 1; id_rs = 31; id_use_rs = 1;
      ex_memrd = 1; ex_regwr = 1; ex_wdst = 31;
      #1;
      total++;
      if (dut_v !== V_LU) begin bad++; $display("FAIL jr_cycle1 act=%b req=%b", dut_v, V_LU); end
      tick();
      ex_memrd = 0; ex_regwr = 0; ex_wdst = 0;
      mem_memrd = 1; mem_wdst = 31;
      #1;
      total++;
      if (dut_v !== V_LU) begin bad++; $display("FAIL jr_cycle2 act=%b req=%b", dut_v, V_LU); end
      tick();
      mem_memrd = 0; mem_wdst = 0;
      #1;
      total++;
      if (dut_v !== V_JMP) begin bad++; $display("FAIL jr_cycle3 act=%b req=%b", dut_v, V_JMP); end
      tick();
      id_use_rs = 0; ex_regwr = 1; ex_wdst = 31;
      #1;
      total++;
      if (dut_v !== V_LU) begin bad++; $display("FAIL jr_alu_dep act=%b req=%b", dut_v, V_LU); end
      tick();
   endtask

   task automatic test_mem_wait();
      clear_inputs();
      mem_req = 1;
      for (int i = 0; i < 3; i++) begin
         ex_br_taken = (i == 1);
         #1;
         total++;
         if (dut_v !== V_STALL) begin bad++; $display("FAIL memwait_hold%0d act=%b req=%b", i, dut_v, V_STALL); end
         tick();
      end
      ex_br_taken = 0; mem_ack = 1;
      #1;
      total++;
      if (dut_v !== V_NONE) begin bad++; $display("FAIL memwait_release act=%b req=%b", dut_v, V_NONE); end
      tick();
      #1;
      total++;
      if (dut_v !== V_NONE) begin bad++; $display("FAIL memwait_same_cycle act=%b req=%b", dut_v, V_NONE); end
      tick();
      mem_req = 0; mem_ack = 0;
      #1;
      total++;
      if (dut_v !== V_NONE) begin bad++; $display("FAIL memwait_back_in_run act=%b req=%b", dut_v, V_NONE); end
      tick();
   endtask

   task automatic test_timeout();
      clear_inputs();
      mem_req = 1;
      for (int i = 0; i < TMO; i++) begin
         #1;
         total++;
         if (dut_v !== V_STALL) begin bad++; $display("FAIL timeout_hold%0d act=%b req=%b", i, dut_v, V_STALL); end
         tick();
      end
      #1;
      total++;
      if (dut_v !== V_TOHIT) begin bad++; $display("FAIL timeout_hit act=%b req=%b", dut_v, V_TOHIT); end
      tick();
      mem_req = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++;
         if (mem_timeout !== 1'b1) begin bad++; $display("FAIL timeout_sticky%0d act=%b req=1", i, mem_timeout); end
         total++;
         if (dut_v !== V_NONE) begin bad++; $display("FAIL timeout_after%0d act=%b req=%b", i, dut_v, V_NONE); end
         tick();
      end
   endtask

   task automatic test_reset_mid_wait();
      clear_inputs();
      mem_req = 1;
      #1;
      tick();
      #1;
      total++;
      if (dut_v !== V_STALL) begin bad++; $display("FAIL rstwait_in_wait act=%b req=%b", dut_v, V_STALL); end
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      total++;
      if (dut_v !== V_NONE) begin bad++; $display("FAIL rstwait_outputs act=%b req=%b", dut_v, V_NONE); end
      total++;
      if (mem_timeout !== 1'b0) begin bad++; $display("FAIL rstwait_timeout act=%b req=0", mem_timeout); end
`ifdef PIPE_HAZARD_PERF_EN
      total++;
      if ({perf_lu, perf_flush, perf_memwait} !== 48'd0) begin
         bad++; $display("FAIL rstwait_perf act=%0d/%0d/%0d req=0/0/0", perf_lu, perf_flush, perf_memwait);
      end
`endif
      @(negedge clk);
      mem_req = 0;
      reset = 1'b0;
      #1;
      total++;
      if (dut_v !== V_NONE) begin bad++; $display("FAIL rstwait_state_run act=%b req=%b", dut_v, V_NONE); end
      tick();
   endtask

   task automatic test_random();
      logic [6:0] exp;
      for (int n = 0; n < 600; n++) begin
         id_rs       = 5'($urandom_range(0, 3));
         id_rt       = 5'($urandom_range(0, 3));
         ex_wdst     = 5'($urandom_range(0, 3));
         mem_wdst    = 5'($urandom_range(0, 3));
         id_use_rs   = 1'($urandom_range(0, 1));
         id_use_rt   = 1'($urandom_range(0, 1));
         id_jump     = ($urandom_range(0, 3) == 0);
         id_jr       = ($urandom_range(0, 3) == 0);
         ex_memrd    = ($urandom_range(0, 2) == 0);
         ex_regwr    = 1'($urandom_range(0, 1));
         mem_memrd   = ($urandom_range(0, 2) == 0);
         ex_br_taken = ($urandom_range(0, 5) == 0);
         mem_req     = ($urandom_range(0, 4) == 0);
         mem_ack     = ($urandom_range(0, 4) == 0);
         #1;
         exp = model_out();
         total++;
         if (dut_v !== exp) begin bad++; $display("FAIL rand_out%0d act=%b req=%b", n, dut_v, exp); end
         total++;
         if (mem_timeout !== m_to) begin bad++; $display("FAIL rand_timeout%0d act=%b req=%b", n, mem_timeout, m_to); end
`ifdef PIPE_HAZARD_PERF_EN
         total++;
         if (perf_lu !== 16'(m_plu) || perf_flush !== 16'(m_pfl) || perf_memwait !== 16'(m_pmw)) begin
            bad++;
            $display("FAIL rand_perf%0d act=%0d/%0d/%0d req=%0d/%0d/%0d", n,
                     perf_lu, perf_flush, perf_memwait, m_plu, m_pfl, m_pmw);
         end
`endif
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch_priority();
      test_jr();
      test_mem_wait();
      test_timeout();
      test_reset_mid_wait();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
